ahbl_splitter: RTL

AHBL_SPLITTER -- requirements
Module: ahbl_splitter

---
 rtl/ahbl_pkg.sv | 23 ++
 rtl/ahbl_splitter_decode.sv | 26 ++
 rtl/ahbl_splitter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the decode-error FSM state type for the splitter.
package ahbl_pkg;

  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransBusy   = 2'b01;
  localparam logic [1:0] HtransNonseq = 2'b10;
  localparam logic [1:0] HtransSeq    = 2'b11;

  localparam logic [2:0] HsizeByte  = 3'b000;
  localparam logic [2:0] HsizeHalf  = 3'b001;
  localparam logic [2:0] HsizeWord  = 3'b010;
  localparam logic [2:0] HsizeDword = 3'b011;

  localparam logic HrespOkay  = 1'b0;
  localparam logic HrespError = 1'b1;

  typedef enum logic [1:0] {
    ErrIdle = 2'b00,
    ErrErr1 = 2'b01,
    ErrErr2 = 2'b10
  } err_state_e;

endpackage

// File: rtl/ahbl_splitter_decode.sv
// Priority address decoder: one-hot port select (lowest matching index wins) plus a no-match flag.
module ahbl_splitter_decode #(
  parameter int unsigned                    N_PORTS   = 2,
  parameter int unsigned                    W_ADDR    = 32,
  parameter logic [N_PORTS*W_ADDR-1:0]      ADDR_MAP  = {32'h2000_0000, 32'h0000_0000},
  parameter logic [N_PORTS*W_ADDR-1:0]      ADDR_MASK = {32'hf000_0000, 32'hf000_0000}
) (
  input  logic [W_ADDR-1:0]  i_haddr,
  output logic [N_PORTS-1:0] o_sel,
  output logic               o_none
);

  always_comb begin
    o_sel  = '0;
    o_none = 1'b1;
    // Walk downwards so the lowest matching index is the last to overwrite.
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if ((i_haddr & ADDR_MASK[i*W_ADDR +: W_ADDR]) == ADDR_MAP[i*W_ADDR +: W_ADDR]) begin
        o_sel    = '0;
        o_sel[i] = 1'b1;
        o_none   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ahbl_splitter.sv
// AHB-Lite 1-to-N splitter: routes address phases by decode, muxes data-phase responses.
// Define AHBL_SPLITTER_DECODE_ERR_EN to answer unmapped accesses with a two-cycle ERROR response.
module ahbl_splitter
  import ahbl_pkg::*;
#(
  parameter int unsigned               N_PORTS   = 2,
  parameter int unsigned               W_ADDR    = 32,
  parameter int unsigned               W_DATA    = 32,
  parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = {32'h2000_0000, 32'h0000_0000},
  parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = {32'hf000_0000, 32'hf000_0000}
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        src_hready,
  output logic                        src_hready_resp,
  output logic                        src_hresp,
  input  logic [W_ADDR-1:0]           src_haddr,
  input  logic                        src_hwrite,
  input  logic [1:0]                  src_htrans,
  input  logic [2:0]                  src_hsize,
  input  logic [2:0]                  src_hburst,
  input  logic [3:0]                  src_hprot,
  input  logic                        src_hmastlock,
  input  logic [W_DATA-1:0]           src_hwdata,
  output logic [W_DATA-1:0]           src_hrdata,
  output logic [N_PORTS-1:0]          dst_hready,
  input  logic [N_PORTS-1:0]          dst_hready_resp,
  input  logic [N_PORTS-1:0]          dst_hresp,
  output logic [N_PORTS*W_ADDR-1:0]   dst_haddr,
  output logic [N_PORTS-1:0]          dst_hwrite,
  output logic [N_PORTS*2-1:0]        dst_htrans,
  output logic [N_PORTS*3-1:0]        dst_hsize,
  output logic [N_PORTS*3-1:0]        dst_hburst,
  output logic [N_PORTS*4-1:0]        dst_hprot,
  output logic [N_PORTS-1:0]          dst_hmastlock,
  output logic [N_PORTS*W_DATA-1:0]   dst_hwdata,
  input  logic [N_PORTS*W_DATA-1:0]   dst_hrdata
);

  logic [N_PORTS-1:0] w_sel;
  logic               w_none;
  logic               w_accept;
  logic [N_PORTS-1:0] r_dsel;
  logic               w_err_active;
  logic               w_err_ready;
  logic               w_err_resp;

  ahbl_splitter_decode #(
    .N_PORTS   (N_PORTS),
    .W_ADDR    (W_ADDR),
    .ADDR_MAP  (ADDR_MAP),
    .ADDR_MASK (ADDR_MASK)
  ) u_decode (
    .i_haddr (src_haddr),
    .o_sel   (w_sel),
    .o_none  (w_none)
  );

  assign w_accept = src_hready & src_htrans[1];

  assign dst_hready    = {N_PORTS{src_hready}};
  assign dst_haddr     = {N_PORTS{src_haddr}};
  assign dst_hwrite    = {N_PORTS{src_hwrite}};
  assign dst_hsize     = {N_PORTS{src_hsize}};
  assign dst_hburst    = {N_PORTS{src_hburst}};
  assign dst_hprot     = {N_PORTS{src_hprot}};
  assign dst_hmastlock = {N_PORTS{src_hmastlock}};
  assign dst_hwdata    = {N_PORTS{src_hwdata}};

  always_comb begin
    dst_htrans = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      dst_htrans[i*2 +: 2] = w_sel[i] ? src_htrans : HtransIdle;
    end
  end

  // Data-phase owner; stays zero for unmapped accesses so the default response applies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dsel <= '0;
    end else if (src_hready) begin
      r_dsel <= (src_htrans[1] && !w_none) ? w_sel : '0;
    end
  end

`ifdef AHBL_SPLITTER_DECODE_ERR_EN
  err_state_e r_err;
  err_state_e w_err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= ErrIdle;
    end else begin
      r_err <= w_err_next;
    end
  end

  always_comb begin
    w_err_next   = r_err;
    w_err_active = 1'b0;
    w_err_ready  = 1'b1;
    w_err_resp   = HrespOkay;
    unique case (r_err)
      ErrIdle: begin
        if (w_accept && w_none) w_err_next = ErrErr1;
      end
      ErrErr1: begin
        w_err_active = 1'b1;
        w_err_ready  = 1'b0;
        w_err_resp   = HrespError;
        w_err_next   = ErrErr2;
      end
      ErrErr2: begin
        w_err_active = 1'b1;
        w_err_resp   = HrespError;
        w_err_next   = (w_accept && w_none) ? ErrErr1 : ErrIdle;
      end
      default: w_err_next = ErrIdle;
    endcase
  end
`else
  assign w_err_active = 1'b0;
  assign w_err_ready  = 1'b1;
  assign w_err_resp   = HrespOkay;
`endif

  always_comb begin
    src_hready_resp = 1'b1;
    src_hresp       = HrespOkay;
    src_hrdata      = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (r_dsel[i]) begin
        src_hready_resp = dst_hready_resp[i];
        src_hresp       = dst_hresp[i];
        src_hrdata      = dst_hrdata[i*W_DATA +: W_DATA];
      end
    end
    if (w_err_active) begin
      src_hready_resp = w_err_ready;
      src_hresp       = w_err_resp;
    end
  end

endmodule
